ex_lsq: RTL and testbench
=========================

// Module: ex_lsq
// PURPOSE
//  Parametrised load/store execution unit: successor to the single-slot LS stage. Holds up to DEPTH
//  operand-ready memory ops in an in-order queue and issues them one at a time to the cache.
//  Loads write back to the regfile; misaligned accesses are flagged; pending work is flushable.
//  Sits between the LS reservation/allocator and the data cache port.
// PARAMETERS
//  DEPTH  4  queue entries (power of 2, >=2)
//  XLEN   32 data/address width
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous active-high reset
//  rdy          in   1        global enable; when low all state holds
//  req_valid    in   1        allocator presents an op (all tags already UNLOCKED)
//  req_ready    out  1        = !full (combinational from count, no same-cycle pop bypass)
//  req_op       in   `sinst_t LB/LH/LW/LBU/LHU/SB/SH/SW; others are ignored (not enqueued)
//  req_base     in   XLEN     rs1 value
//  req_offset   in   XLEN     sign-extended immediate
//  req_sdata    in   XLEN     store data (rs2)
//  req_target   in   `regaddr_t load destination
//  flush        in   1        drop all unissued entries
//  busy         out  1        queue non-empty or FSM not IDLE
//  wb_en        out  1        one-cycle regfile write strobe
//  wb_target    out  `regaddr_t
//  wb_data      out  XLEN
//  cache_en     out  1        request valid; held until cache_accept
//  cache_oper   out  1        `READ_SIGNAL / `WRITE_SIGNAL
//  cache_addr   out  `addr_t   base+offset, mod 2^XLEN
//  cache_size   out  `byte_t   1, 2 or 4 (LHU/SH = 2)
//  cache_data   out  XLEN     store data, low bytes significant
//  cache_accept in   1        cache took the request this cycle
//  cache_finish in   1        load data valid on cache_rdata
//  cache_rdata  in   XLEN     little-endian: byte at addr in [7:0]
//  misalign     out  1        one-cycle pulse: head op misaligned, dropped
// BEHAVIOUR
//  Reset: queue empty, FSM IDLE; busy, wb_en, cache_en, misalign = 0; wb_target = `ZERO; other data 0.
//  Enqueue when req_valid && req_ready && rdy && !flush; address computed at enqueue.
//  FSM: IDLE -> REQ when queue non-empty (head is visible the cycle after enqueue).
//   IDLE: if head misaligned (H: addr[0]; W: addr[1:0]!=0) pulse misalign, pop, stay IDLE.
//   REQ: cache_en=1. On cache_accept: store -> pop, IDLE; load -> pop, WAIT.
//   WAIT: on cache_finish, register wb_data (LB/LH sign-extend, LBU/LHU zero-extend, LW as-is),
//         wb_en=1 for exactly one cycle, -> IDLE. Target `ZERO: no wb_en.
//   DRAIN: as WAIT but result discarded (wb_en stays 0).
//  Latency: enqueue at N -> earliest cache_en at N+2; load wb_en the cycle after cache_finish.
//  Back-to-back: the cycle after a store accept may already show the next head's cache_en only via IDLE
//   (one bubble per op; throughput 1 op / 2 cycles minimum).
//  flush: queue count -> 0 next cycle. REQ without accept -> IDLE (request withdrawn). REQ with
//   same-cycle accept: store completes, load -> DRAIN. WAIT -> DRAIN. Flush with same-cycle
//   cache_finish in WAIT: result discarded.
//  Full: req_ready=0; a pop in the same cycle does not admit a push.
//  rdy low: state and queue frozen; wb_en and misalign forced 0 (no duplicate strobes).
//  rst mid-operation: everything to reset values next edge; a late cache_finish is ignored in IDLE.
// STRUCTURE
//  Shared defines header: `sinst_t op codes, `READ_SIGNAL/`WRITE_SIGNAL, `ZERO, `NULL_PTR, width macros.
//  One sub-module: lsq_fifo (DEPTH-entry circular buffer, wrap-around pointers, count, push/pop/clear).
//  Load-data formatting and misalign check stay inline.
// TESTING
//  LW base=0x100 off=4, rdata=0x80FF_1234 -> cache_addr=0x104 size=4, wb_data=0x80FF1234, wb_en 1 cycle.
//  LB then LBU at 0x3, rdata[7:0]=0x9C -> wb_data 0xFFFFFF9C then 0x0000009C, in order.
//  Fill DEPTH=4 stores with cache_accept low -> req_ready=0 after 4th; release -> 4 writes in order.
//  LW at 0x102 -> misalign pulse, no cache_en, no wb_en; following SW at 0x200 issues normally.
//  Load accepted, flush before cache_finish -> DRAIN, no wb_en; 3 queued ops dropped, busy=0 after.
//  rst asserted in WAIT with cache_finish next cycle -> all outputs reset, wb_en stays 0.

Source files
------------

// File: rtl/ex_lsq_pkg.sv
// ex_lsq_pkg: op codes, cache signalling constants and helpers shared by the load/store queue
package ex_lsq_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ALU
  } sinst_t;
  typedef logic [4:0] regaddr_t;
  typedef logic [2:0] byte_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
  localparam regaddr_t ZERO = 5'd0;
  localparam logic READ_SIGNAL = 1'b0;
  localparam logic WRITE_SIGNAL = 1'b1;
  localparam int OP_W = 4;
  localparam int REG_W = 5;
  function automatic logic is_load(sinst_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction
  function automatic logic is_store(sinst_t op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic byte_t op_size(sinst_t op);
    return op inside {OP_LW, OP_SW} ? 3'd4 : op inside {OP_LH, OP_LHU, OP_SH} ? 3'd2 : 3'd1;
  endfunction
  function automatic logic misaligned(sinst_t op, logic [1:0] a);
    return op_size(op) == 3'd4 ? a != 2'b00 : op_size(op) == 3'd2 ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/ex_lsq_fifo.sv
// ex_lsq_fifo: DEPTH-entry circular buffer with push/pop/clear and a global enable
module ex_lsq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (en) begin
      if (clear) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        wp <= wp + AW'(do_push);
        rp <= rp + AW'(do_pop);
        cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  always_ff @(posedge clk)
    if (en && do_push && !clear) mem[wp] <= din;
endmodule

// File: rtl/ex_lsq.sv
// ex_lsq: in-order load/store queue issuing one memory op at a time to the data cache
module ex_lsq
  import ex_lsq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            req_valid,
  output logic            req_ready,
  input  sinst_t          req_op,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_sdata,
  input  regaddr_t        req_target,
  input  logic            flush,
  output logic            busy,
  output logic            wb_en,
  output regaddr_t        wb_target,
  output logic [XLEN-1:0] wb_data,
  output logic            cache_en,
  output logic            cache_oper,
  output logic [XLEN-1:0] cache_addr,
  output byte_t           cache_size,
  output logic [XLEN-1:0] cache_data,
  input  logic            cache_accept,
  input  logic            cache_finish,
  input  logic [XLEN-1:0] cache_rdata,
  output logic            misalign
);
  localparam int W = OP_W + REG_W + 2 * XLEN;
  logic [W-1:0] head;
  logic empty, full, push, pop, mis, req_on, fin;
  sinst_t head_op, cur_op;
  regaddr_t head_target, cur_target;
  logic [XLEN-1:0] head_sdata, head_addr, ld_data;
  state_t state, state_n;
  assign req_ready = !full;
  assign push = req_valid && req_ready && rdy && !flush && (is_load(req_op) || is_store(req_op));
  ex_lsq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .en(rdy), .push(push), .pop(pop), .clear(flush),
    .din({req_op, req_target, req_sdata, req_base + req_offset}),
    .dout(head), .empty(empty), .full(full)
  );
  assign head_op = sinst_t'(head[W-1 -: OP_W]);
  assign head_target = head[W-OP_W-1 -: REG_W];
  assign head_sdata = head[2*XLEN-1 -: XLEN];
  assign head_addr = head[XLEN-1:0];
  assign mis = !empty && misaligned(head_op, head_addr[1:0]);
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      S_IDLE:
        if (!empty && !flush) begin
          pop = mis;
          state_n = mis ? S_IDLE : S_REQ;
        end
      S_REQ:
        if (cache_accept) begin
          pop = 1'b1;
          state_n = is_store(head_op) ? S_IDLE : flush ? S_DRAIN : S_WAIT;
        end else if (flush) state_n = S_IDLE;
      S_WAIT:  state_n = cache_finish ? S_IDLE : flush ? S_DRAIN : S_WAIT;
      S_DRAIN: state_n = cache_finish ? S_IDLE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end
  assign req_on = state == S_REQ;
  assign cache_en = rdy && req_on;
  assign cache_oper = req_on && is_store(head_op) ? WRITE_SIGNAL : READ_SIGNAL;
  assign cache_addr = req_on ? head_addr : '0;
  assign cache_size = req_on ? op_size(head_op) : '0;
  assign cache_data = req_on ? head_sdata : '0;
  assign misalign = rdy && state == S_IDLE && !flush && mis;
  assign busy = !empty || state != S_IDLE;
  assign fin = state == S_WAIT && cache_finish && !flush;
  assign ld_data = cur_op == OP_LB  ? {{(XLEN-8){cache_rdata[7]}}, cache_rdata[7:0]} :
                   cur_op == OP_LH  ? {{(XLEN-16){cache_rdata[15]}}, cache_rdata[15:0]} :
                   cur_op == OP_LBU ? {{(XLEN-8){1'b0}}, cache_rdata[7:0]} :
                   cur_op == OP_LHU ? {{(XLEN-16){1'b0}}, cache_rdata[15:0]} : cache_rdata;
  // op and target are captured at accept because the entry is popped then
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cur_op <= OP_NOP;
      cur_target <= ZERO;
      wb_en <= 1'b0;
      wb_target <= ZERO;
      wb_data <= '0;
    end else if (!rdy) wb_en <= 1'b0;
    else begin
      state <= state_n;
      if (req_on && cache_accept) begin
        cur_op <= head_op;
        cur_target <= head_target;
      end
      wb_en <= fin && cur_target != ZERO;
      if (fin) begin
        wb_target <= cur_target;
        wb_data <= ld_data;
      end
    end
endmodule

// File: tb/tb_ex_lsq.sv
// tb_ex_lsq: scoreboard bench for ex_lsq with an auto-responding cache model
module tb_ex_lsq;
  import ex_lsq_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, req_valid = 1'b0, flush = 1'b0;
  logic cache_accept = 1'b0, cache_finish = 1'b0;
  sinst_t req_op = OP_NOP;
  logic [31:0] req_base = '0, req_offset = '0, req_sdata = '0, cache_rdata = '0;
  regaddr_t req_target = ZERO;
  logic req_ready, busy, wb_en, cache_en, cache_oper, misalign;
  regaddr_t wb_target;
  logic [31:0] wb_data, cache_addr, cache_data;
  byte_t cache_size;

  ex_lsq #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base), .req_offset(req_offset), .req_sdata(req_sdata),
    .req_target(req_target), .flush(flush), .busy(busy), .wb_en(wb_en),
    .wb_target(wb_target), .wb_data(wb_data), .cache_en(cache_en), .cache_oper(cache_oper),
    .cache_addr(cache_addr), .cache_size(cache_size), .cache_data(cache_data),
    .cache_accept(cache_accept), .cache_finish(cache_finish), .cache_rdata(cache_rdata),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic oper; byte_t size; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct packed {regaddr_t tgt; logic [31:0] data;} wb_t;
  typedef struct {int kind; logic [63:0] exp; string name;} probe_t;
  req_t exp_req[$];
  wb_t exp_wb[$];
  int exp_mis[$];
  logic [31:0] rdq[$];
  probe_t probes[$];
  int checks = 0, errors = 0;
  logic auto_acc = 1'b1, hold_fin = 1'b0, pend_ld = 1'b0;
  localparam logic [63:0] RESET_VEC = 64'h0000_0000_0200_0000;

  // cache model: accepts whenever enabled, answers loads one cycle later unless held
  initial forever begin
    @(posedge clk);
    #2;
    cache_finish = 1'b0;
    if (pend_ld && !hold_fin) begin
      cache_finish = 1'b1;
      cache_rdata = rdq.size() > 0 ? rdq.pop_front() : 32'h0;
      pend_ld = 1'b0;
    end
    cache_accept = auto_acc && cache_en;
    if (cache_accept && cache_oper == READ_SIGNAL) pend_ld = 1'b1;
  end

  task automatic check(string name, logic [67:0] got, logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  logic [63:0] g;
  probe_t p;
  initial forever begin
    @(negedge clk);
    if (cache_en && cache_accept) begin
      check("cache_req_pending", 68'(exp_req.size() > 0), 68'd1);
      if (exp_req.size() > 0) check("cache_req", {cache_oper, cache_size, cache_addr, cache_data}, 68'(exp_req.pop_front()));
    end
    if (wb_en) begin
      check("wb_pending", 68'(exp_wb.size() > 0), 68'd1);
      if (exp_wb.size() > 0) check("wb", 68'({wb_target, wb_data}), 68'(exp_wb.pop_front()));
    end
    if (misalign) begin
      check("misalign_pending", 68'(exp_mis.size() > 0), 68'd1);
      if (exp_mis.size() > 0) void'(exp_mis.pop_front());
    end
    while (probes.size() > 0) begin
      p = probes.pop_front();
      g = {2'b0, wb_data, busy, wb_en, cache_en, misalign, req_ready, wb_target, cache_size, cache_oper, cache_addr[15:0]};
      case (p.kind)
        0: check(p.name, 68'(cache_en), 68'(p.exp));
        1: check(p.name, 68'(req_ready), 68'(p.exp));
        2: check(p.name, 68'(busy), 68'(p.exp));
        3: check(p.name, 68'(g), 68'(p.exp));
        4: check(p.name, 68'd1, 68'd0);
        default: begin
          check("end_req_queue", 68'(exp_req.size()), 68'd0);
          check("end_wb_queue", 68'(exp_wb.size()), 68'd0);
          check("end_mis_queue", 68'(exp_mis.size()), 68'd0);
        end
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic probe(int k, logic [63:0] e, string n);
    probes.push_back('{k, e, n});
  endtask
  task automatic enq(sinst_t op, logic [31:0] b, logic [31:0] o, logic [31:0] d, regaddr_t t);
    req_op = op;
    req_base = b;
    req_offset = o;
    req_sdata = d;
    req_target = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask
  task automatic ld(sinst_t op, logic [31:0] b, logic [31:0] o, regaddr_t t, logic [31:0] rd,
                    logic [31:0] ea, byte_t sz, logic [31:0] ewb, logic wbx);
    exp_req.push_back(req_t'({READ_SIGNAL, sz, ea, 32'h0}));
    rdq.push_back(rd);
    if (wbx) exp_wb.push_back(wb_t'({t, ewb}));
    enq(op, b, o, 32'h0, t);
  endtask
  task automatic st(sinst_t op, logic [31:0] b, logic [31:0] o, logic [31:0] d, logic [31:0] ea, byte_t sz);
    exp_req.push_back(req_t'({WRITE_SIGNAL, sz, ea, d}));
    enq(op, b, o, d, 5'd1);
  endtask
  task automatic wait_idle;
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) probe(4, 64'h0, "idle_timeout");
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    probe(3, RESET_VEC, "reset_outputs");
    ld(OP_LW, 32'h100, 32'h4, 5'd5, 32'h80FF_1234, 32'h104, 3'd4, 32'h80FF_1234, 1'b1);
    probe(0, 64'h0, "cache_en_n_plus_1");
    tick();
    probe(0, 64'h1, "cache_en_n_plus_2");
    wait_idle();
    ld(OP_LB,  32'h0,  32'h3, 5'd6, 32'h0000_009C, 32'h3,  3'd1, 32'hFFFF_FF9C, 1'b1);
    ld(OP_LBU, 32'h0,  32'h3, 5'd7, 32'h1234_569C, 32'h3,  3'd1, 32'h0000_009C, 1'b1);
    ld(OP_LH,  32'h10, 32'h0, 5'd8, 32'h0000_8001, 32'h10, 3'd2, 32'hFFFF_8001, 1'b1);
    ld(OP_LHU, 32'h10, 32'h2, 5'd9, 32'hABCD_8001, 32'h12, 3'd2, 32'h0000_8001, 1'b1);
    ld(OP_LW,  32'h20, 32'h0, ZERO, 32'h5555_5555, 32'h20, 3'd4, 32'h0, 1'b0);
    wait_idle();
    auto_acc = 1'b0;
    st(OP_SB, 32'h40, 32'h1, 32'h1122_3344, 32'h41, 3'd1);
    st(OP_SH, 32'h50, 32'hFFFF_FFFE, 32'hAABB_CCDD, 32'h4E, 3'd2);
    st(OP_SW, 32'h60, 32'h0, 32'hCAFE_F00D, 32'h60, 3'd4);
    st(OP_SW, 32'hFFFF_FFFC, 32'h8, 32'h0102_0304, 32'h4, 3'd4);
    probe(1, 64'h0, "ready_when_full");
    enq(OP_SW, 32'h70, 32'h0, 32'h0BAD_0BAD, 5'd1);
    probe(2, 64'h1, "busy_when_full");
    auto_acc = 1'b1;
    wait_idle();
    exp_mis.push_back(1);
    enq(OP_LW, 32'h100, 32'h2, 32'h0, 5'd4);
    exp_mis.push_back(1);
    enq(OP_SH, 32'h201, 32'h0, 32'h1, 5'd1);
    st(OP_SW, 32'h200, 32'h0, 32'hDEAD_BEEF, 32'h200, 3'd4);
    wait_idle();
    hold_fin = 1'b1;
    ld(OP_LW, 32'h300, 32'h0, 5'd9, 32'h7777_7777, 32'h300, 3'd4, 32'h0, 1'b0);
    enq(OP_SW, 32'h304, 32'h0, 32'h1, 5'd1);
    enq(OP_SW, 32'h308, 32'h0, 32'h2, 5'd1);
    enq(OP_LW, 32'h30C, 32'h0, 32'h0, 5'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    probe(2, 64'h1, "busy_in_drain");
    hold_fin = 1'b0;
    wait_idle();
    probe(2, 64'h0, "busy_after_flush");
    tick();
    rdy = 1'b0;
    enq(OP_LW, 32'h500, 32'h0, 32'h0, 5'd3);
    rdy = 1'b1;
    probe(2, 64'h0, "busy_after_rdy_low_req");
    tick();
    hold_fin = 1'b1;
    ld(OP_LW, 32'h400, 32'h0, 5'd3, 32'h1234_5678, 32'h400, 3'd4, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_fin = 1'b0;
    probe(3, RESET_VEC, "reset_in_wait");
    repeat (4) tick();
    probe(5, 64'h0, "end");
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
